// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered RV32I(+M) ALU control decoder with valid/ready
// handshake and a busy counter that models multi-cycle MUL/DIV latency.
module alu_ctrl_seq #(
  parameter int unsigned CTRL_W  = 5,
  parameter bit          EN_M    = 1'b1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        Funct3,
  input  logic [6:0]        Funct7,
  input  logic              Op_5,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              Is_MulDiv,
  output logic              Illegal,
  output logic              Busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = ($clog2(MAX_LAT) > 0) ? $clog2(MAX_LAT) : 1;
  localparam int unsigned MUL_CNT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int unsigned DIV_CNT = (DIV_LAT > 1) ? DIV_LAT - 2 : 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam logic [4:0] C_ADD  = 5'b00000;
  localparam logic [4:0] C_SUB  = 5'b00001;
  localparam logic [4:0] C_AND  = 5'b00010;
  localparam logic [4:0] C_OR   = 5'b00011;
  localparam logic [4:0] C_XOR  = 5'b00100;
  localparam logic [4:0] C_SLT  = 5'b00101;
  localparam logic [4:0] C_SLL  = 5'b00110;
  localparam logic [4:0] C_SRL  = 5'b00111;
  localparam logic [4:0] C_SRA  = 5'b01000;
  localparam logic [4:0] C_SLTU = 5'b01001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              md_q, md_d;
  logic              ill_q, ill_d;

  logic [4:0] dec_code;
  logic       dec_ill;
  logic       dec_md;
  logic       dec_div;
  logic       accept;

  // Combinational decode of the current request fields
  always_comb begin
    dec_code = C_ADD;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    dec_div  = 1'b0;
    unique case (ALUOp)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b11: dec_ill  = 1'b1;
      default: begin
        if (Op_5 && (Funct7 == F7_MD)) begin
          if (EN_M) begin
            dec_code = {2'b10, Funct3};
            dec_md   = 1'b1;
            dec_div  = Funct3[2];
          end else begin
            dec_ill  = 1'b1;
          end
        end else if (Op_5 && (Funct7 != F7_BASE) && (Funct7 != F7_ALT)) begin
          dec_ill = 1'b1;
        end else if (Op_5 && (Funct7 == F7_ALT) && (Funct3 != 3'b000) && (Funct3 != 3'b101)) begin
          dec_ill = 1'b1;
        end else if (!Op_5 && (Funct3 == 3'b001) && (Funct7 != F7_BASE)) begin
          dec_ill = 1'b1;
        end else if (!Op_5 && (Funct3 == 3'b101) && (Funct7 != F7_BASE) && (Funct7 != F7_ALT)) begin
          dec_ill = 1'b1;
        end else begin
          unique case (Funct3)
            3'b000:  dec_code = (Op_5 && Funct7[5]) ? C_SUB : C_ADD;
            3'b001:  dec_code = C_SLL;
            3'b010:  dec_code = C_SLT;
            3'b011:  dec_code = C_SLTU;
            3'b100:  dec_code = C_XOR;
            3'b101:  dec_code = Funct7[5] ? C_SRA : C_SRL;
            3'b110:  dec_code = C_OR;
            default: dec_code = C_AND;
          endcase
        end
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_VALID) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_VALID);
  assign Busy      = (state_q == S_WAIT);
  assign ALUControl = ctrl_q;
  assign Is_MulDiv = md_q;
  assign Illegal   = ill_q;

  // Next-state and output-register load logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    md_d    = md_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_VALID;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_VALID: begin
        if (out_ready && !in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      ctrl_d = CTRL_W'(dec_code);
      md_d   = dec_md;
      ill_d  = dec_ill;
      cnt_d  = '0;
      if (dec_md && dec_div && (DIV_LAT > 1)) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(DIV_CNT);
      end else if (dec_md && !dec_div && (MUL_LAT > 1)) begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(MUL_CNT);
      end else begin
        state_d = S_VALID;
      end
    end
  end

  // State and output registers; reset discards any in-flight op
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      md_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      md_q    <= md_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench: three instances share stimulus (default, EN_M=0, MUL_LAT=4).
module tb_alu_ctrl_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic [1:0] ALUOp;
  logic [2:0] Funct3;
  logic [6:0] Funct7;
  logic       Op_5;
  logic       out_ready;

  logic       a_ir, a_ov, a_md, a_il, a_bz;
  logic [4:0] a_ctrl;
  logic       b_ir, b_ov, b_md, b_il, b_bz;
  logic [4:0] b_ctrl;
  logic       c_ir, c_ov, c_md, c_il, c_bz;
  logic [4:0] c_ctrl;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_ctrl_seq #(.CTRL_W(5), .EN_M(1'b1), .MUL_LAT(2), .DIV_LAT(32)) dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(a_ir), .ALUOp(ALUOp),
    .Funct3(Funct3), .Funct7(Funct7), .Op_5(Op_5), .out_valid(a_ov), .out_ready(out_ready),
    .ALUControl(a_ctrl), .Is_MulDiv(a_md), .Illegal(a_il), .Busy(a_bz));

  alu_ctrl_seq #(.CTRL_W(5), .EN_M(1'b0), .MUL_LAT(2), .DIV_LAT(32)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(b_ir), .ALUOp(ALUOp),
    .Funct3(Funct3), .Funct7(Funct7), .Op_5(Op_5), .out_valid(b_ov), .out_ready(out_ready),
    .ALUControl(b_ctrl), .Is_MulDiv(b_md), .Illegal(b_il), .Busy(b_bz));

  alu_ctrl_seq #(.CTRL_W(5), .EN_M(1'b1), .MUL_LAT(4), .DIV_LAT(32)) dut_c (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(c_ir), .ALUOp(ALUOp),
    .Funct3(Funct3), .Funct7(Funct7), .Op_5(Op_5), .out_valid(c_ov), .out_ready(out_ready),
    .ALUControl(c_ctrl), .Is_MulDiv(c_md), .Illegal(c_il), .Busy(c_bz));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic o5);
    ALUOp = op; Funct3 = f3; Funct7 = f7; Op_5 = o5;
  endtask

  // One single-cycle request on dut_a: accept, check result, drain back to idle
  task automatic send1(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic o5, input logic [4:0] ecode,
                       input logic eill);
    set_op(op, f3, f7, o5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_vld_code_ill"}, {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, ecode});
    chk({tag, "_ill_md"}, {30'd0, a_il, a_md}, {30'd0, eill, 1'b0});
    step();
    chk({tag, "_idle"}, {31'd0, a_ov}, 32'd0);
  endtask

  initial begin
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(2'b00, 3'b000, 7'b0, 1'b0);
    step(); step();
    chk("reset_outs", {22'd0, a_ov, a_ctrl, a_md, a_il, a_bz, a_ir}, {22'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    RST = 1'b1;
    step();

    // SUB on the cycle after a single-cycle accept
    set_op(2'b10, 3'b000, 7'b0100000, 1'b1);
    in_valid = 1'b1;
    chk("sub_in_ready", {31'd0, a_ir}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("sub_result", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b00001});
    step();
    chk("sub_drain", {31'd0, a_ov}, 32'd0);

    // Back-to-back stream ADD, SLL, SRA, SLTU
    set_op(2'b10, 3'b000, 7'b0000000, 1'b1); in_valid = 1'b1;
    step(); chk("stream_add", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b00000});
    set_op(2'b10, 3'b001, 7'b0000000, 1'b1);
    step(); chk("stream_sll", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b00110});
    set_op(2'b10, 3'b101, 7'b0100000, 1'b1);
    step(); chk("stream_sra", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b01000});
    set_op(2'b10, 3'b011, 7'b0000000, 1'b1);
    step(); chk("stream_sltu", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b01001});
    in_valid = 1'b0;
    step(); chk("stream_drain", {31'd0, a_ov}, 32'd0);

    // Assorted decode cases
    send1("op00_add", 2'b00, 3'b111, 7'b0100000, 1'b1, 5'b00000, 1'b0);
    send1("op01_sub", 2'b01, 3'b000, 7'b0000000, 1'b0, 5'b00001, 1'b0);
    send1("op11_ill", 2'b11, 3'b100, 7'b0000000, 1'b1, 5'b00000, 1'b1);
    send1("srai", 2'b10, 3'b101, 7'b0100000, 1'b0, 5'b01000, 1'b0);
    send1("addi_f7", 2'b10, 3'b000, 7'b0100000, 1'b0, 5'b00000, 1'b0);
    send1("slli_bad", 2'b10, 3'b001, 7'b0000100, 1'b0, 5'b00000, 1'b1);
    send1("srli_bad", 2'b10, 3'b101, 7'b0000001, 1'b0, 5'b00000, 1'b1);
    send1("r_bad_f7", 2'b10, 3'b000, 7'b0000010, 1'b1, 5'b00000, 1'b1);
    send1("r_alt_and", 2'b10, 3'b111, 7'b0100000, 1'b1, 5'b00000, 1'b1);
    send1("slt", 2'b10, 3'b010, 7'b0000000, 1'b1, 5'b00101, 1'b0);
    send1("ori", 2'b10, 3'b110, 7'b1111111, 1'b0, 5'b00011, 1'b0);
    send1("andi", 2'b10, 3'b111, 7'b0000000, 1'b0, 5'b00010, 1'b0);

    // MUL with MUL_LAT=2 on dut_a: one busy cycle, valid on the second
    set_op(2'b10, 3'b000, 7'b0000001, 1'b1); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("mul_busy", {29'd0, a_bz, a_ov, a_ir}, {29'd0, 3'b100});
    chk("mul_en_m0_ill", {26'd0, b_ov, b_il, b_ctrl[3:0]}, {26'd0, 1'b1, 1'b1, 4'd0});
    step();
    chk("mul_done", {25'd0, a_ov, a_md, a_ctrl}, {25'd0, 1'b1, 1'b1, 5'b10000});
    step();

    // DIV: busy 31 cycles, valid on the 32nd; EN_M=0 flags it illegal in 1 cycle
    set_op(2'b10, 3'b100, 7'b0000001, 1'b1); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    chk("div_en_m0", {25'd0, b_ov, b_il, b_ctrl}, {25'd0, 1'b1, 1'b1, 5'b00000});
    chk("div_en_m0_md", {31'd0, b_md}, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      chk("div_wait", {29'd0, a_bz, a_ov, a_ir}, {29'd0, 3'b100});
      step();
    end
    chk("div_done", {23'd0, a_bz, a_ov, a_md, a_il, a_ctrl}, {23'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b10100});
    step();
    chk("div_drain", {31'd0, a_ov}, 32'd0);

    // Back-pressure: hold XOR for 5 cycles while inputs toggle
    out_ready = 1'b0;
    set_op(2'b10, 3'b100, 7'b0000000, 1'b1); in_valid = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      set_op(2'(k), 3'(k + 1), 7'(k * 5), k[0]);
      chk("hold", {24'd0, a_ov, a_ir, a_il, a_md, a_ctrl}, {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100});
      step();
    end
    chk("hold_end", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b00100});
    set_op(2'b10, 3'b110, 7'b0000000, 1'b1); out_ready = 1'b1;
    #1;
    chk("release_ready", {31'd0, a_ir}, 32'd1);
    step(); in_valid = 1'b0;
    chk("release_or", {26'd0, a_ov, a_ctrl}, {26'd0, 1'b1, 5'b00011});
    step();
    chk("release_drain", {31'd0, a_ov}, 32'd0);

    // Reset mid-WAIT of MUL on dut_c (MUL_LAT=4)
    set_op(2'b10, 3'b011, 7'b0000001, 1'b1); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step();
    chk("mul4_wait", {29'd0, c_bz, c_ov, c_ir}, {29'd0, 3'b100});
    RST = 1'b0;
    #1;
    chk("mid_wait_rst", {22'd0, c_ov, c_ctrl, c_md, c_il, c_bz, c_ir}, {22'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    step(); step();
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no_stale", {30'd0, c_ov, c_bz}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
